winograd_ewmm_scheduler: RTL and testbench
==========================================

// Module: winograd_ewmm_scheduler
// PURPOSE
//  Sequences the Winograd element-wise 6x6 multiply stage over all (tile, channel) pairs of one job.
//  Issues one-cycle start pulses to the fixed-latency pointwise multiplier.
//  Tags each issue with its indices and re-aligns the tags with the multiplier's done pulse.
//  Throttles issue with credits so the downstream accumulator can stall without losing results.
// PARAMETERS
//  MULT_LATENCY  3   cycles from mult_start to mult_done; must equal the multiplier's LATENCY
//  TILE_W        8   width of tile index/count
//  CH_W          6   width of channel index/count
//  CREDITS       4   downstream result slots; range 1..15
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       synchronous, active-low reset
//  job_start     in   1       pulse; accepted only in IDLE
//  cfg_tiles     in   TILE_W  tiles per job, sampled on job_start; 0 = empty job
//  cfg_chans     in   CH_W    channels per tile, sampled on job_start; 0 = empty job
//  op_valid      in   1       operand buffer has a[ ]/b[ ] ready for (op_tile, op_chan)
//  op_ready      out  1       operand consumed this cycle; equals mult_start
//  op_tile       out  TILE_W  tile index requested from the operand buffer
//  op_chan       out  CH_W    channel index requested from the operand buffer
//  mult_start    out  1       start pulse to the multiplier
//  mult_done     in   1       done pulse from the multiplier
//  res_valid     out  1       multiplier output c[ ] valid this cycle; equals the aligned mult_done
//  res_tile      out  TILE_W  tile index of the current result
//  res_chan      out  CH_W    channel index of the current result
//  res_last      out  1       result is the final pair of the job
//  res_ack       in   1       downstream freed one slot; returns one credit
//  busy          out  1       state != IDLE
//  job_done      out  1       one-cycle pulse on DRAIN->IDLE
//  err_align     out  1       sticky; mult_done seen while the tag pipe head is invalid
// BEHAVIOUR
//  Reset: all outputs 0, credits = CREDITS, state IDLE, tag pipe cleared. Reset mid-job aborts the job.
//  FSM:
//   IDLE  -> RUN    on job_start with both cfg nonzero.
//   IDLE  -> IDLE   on job_start with either cfg zero; pulses job_done the next cycle, no issue.
//   RUN   -> DRAIN  on the issue of the last pair (tile = cfg_tiles-1, chan = cfg_chans-1).
//   DRAIN -> IDLE   when no issue is in flight and credits == CREDITS; then pulses job_done.
//  job_start outside IDLE is ignored.
//  Issue order: chan is the inner loop, tile the outer, starting at (0,0).
//  op_tile/op_chan hold their values until issue.
//  mult_start = (state==RUN) && op_valid && (credits!=0).
//  Issue: combinational from registered state; at most one per cycle; back-to-back issue is allowed.
//  Credit counter:
//   issue only:            -1
//   res_ack only:          +1
//   issue and res_ack:     unchanged
//   res_ack at CREDITS:    ignored
//  Tag pipe: MULT_LATENCY-stage shift of {valid, tile, chan, last}; entry pushed on mult_start.
//  res_* is driven from the pipe head; res_valid = mult_done && head.valid.
//  Latency: mult_start at cycle t gives res_valid at t+MULT_LATENCY.
//  busy rises the cycle after an accepted job_start.
// CONFIGURATION
//  WINO_SCHED_PERF_EN defined: adds outputs perf_cycles[31:0] and perf_stall[31:0].
//   perf_cycles counts busy cycles.
//   perf_stall counts RUN cycles with op_valid=1 && credits==0.
//   Both clear on an accepted job_start and saturate at all-ones.
//  WINO_SCHED_PERF_EN undefined: perf ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  winograd_pkg:
//   sched_state_e {IDLE, RUN, DRAIN}
//   sched_tag_t struct {valid, tile, chan, last}
//   default constant WINO_MULT_LATENCY = 3
//  Sub-module winograd_tag_pipe: parameterised-depth shift register of sched_tag_t, sync reset clears valid bits.
// TESTING
//  - tiles=2, chans=3, op_valid=1, res_ack echoes res_valid:
//    6 issues in order (0,0)(0,1)(0,2)(1,0)(1,1)(1,2); each result 3 cycles later;
//    res_last only on (1,2); job_done once.
//  - CREDITS=4, tiles=1, chans=8, res_ack=0 until cycle 20:
//    exactly 4 issues, then mult_start held low; remaining 4 issue after acks.
//  - op_valid toggled 1,0,1,0:
//    issues only on op_valid=1 cycles; indices never skip.
//  - cfg_tiles=0:
//    no mult_start; job_done one cycle after job_start; busy stays 0.
//  - rst_n low for 1 cycle during RUN with 2 issues in flight:
//    next cycle outputs 0, credits=CREDITS; late mult_done raises err_align.
//  - job_start pulsed during RUN:
//    ignored; sequence unchanged.
//  - WINO_SCHED_PERF_EN with the credit-stall test:
//    perf_stall equals the number of stalled cycles.

Source files
------------

// File: rtl/winograd_pkg.sv
// Shared types and defaults for the Winograd element-wise multiply scheduler.
package winograd_pkg;

  localparam int WINO_MULT_LATENCY = 3;
  localparam int WINO_TILE_W       = 8;
  localparam int WINO_CH_W         = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic                   valid;
    logic [WINO_TILE_W-1:0] tile;
    logic [WINO_CH_W-1:0]   chan;
    logic                   last;
  } sched_tag_t;

endpackage

// File: rtl/winograd_tag_pipe.sv
// Fixed-depth shift register carrying issue tags alongside the multiplier,
// so the head lines up with the multiplier's done pulse.
module winograd_tag_pipe
  import winograd_pkg::*;
#(
  parameter int DEPTH = WINO_MULT_LATENCY
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  sched_tag_t i_tag,
  output sched_tag_t o_head,
  output logic       o_any_valid
);

  sched_tag_t r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  always_comb begin
    o_any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) o_any_valid = o_any_valid | r_stage[i].valid;
  end

  assign o_head = r_stage[DEPTH-1];

endmodule

// File: rtl/winograd_ewmm_scheduler.sv
// Issues (tile, channel) pairs to the pointwise multiplier under credit control.
// Optional perf counters are compiled in with WINO_SCHED_PERF_EN.
//   state | meaning
//   IDLE  | waiting for job_start
//   RUN   | issuing pairs, chan inner / tile outer
//   DRAIN | last pair issued, waiting for results and credits to return
module winograd_ewmm_scheduler
  import winograd_pkg::*;
#(
  parameter int MULT_LATENCY = WINO_MULT_LATENCY,
  parameter int TILE_W       = WINO_TILE_W,
  parameter int CH_W         = WINO_CH_W,
  parameter int CREDITS      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_job_start,
  input  logic [TILE_W-1:0] i_cfg_tiles,
  input  logic [CH_W-1:0]   i_cfg_chans,
  input  logic              i_op_valid,
  output logic              o_op_ready,
  output logic [TILE_W-1:0] o_op_tile,
  output logic [CH_W-1:0]   o_op_chan,
  output logic              o_mult_start,
  input  logic              i_mult_done,
  output logic              o_res_valid,
  output logic [TILE_W-1:0] o_res_tile,
  output logic [CH_W-1:0]   o_res_chan,
  output logic              o_res_last,
  input  logic              i_res_ack,
  output logic              o_busy,
  output logic              o_job_done,
  output logic              o_err_align
`ifdef WINO_SCHED_PERF_EN
  ,
  output logic [31:0]       o_perf_cycles,
  output logic [31:0]       o_perf_stall
`endif
);

  localparam logic [3:0]        CRED_FULL = 4'(CREDITS);
  localparam logic [TILE_W-1:0] TILE_ONE  = TILE_W'(1);
  localparam logic [CH_W-1:0]   CH_ONE    = CH_W'(1);

  sched_state_e      r_state;
  logic [TILE_W-1:0] r_tile;
  logic [TILE_W-1:0] r_cfg_tiles;
  logic [CH_W-1:0]   r_chan;
  logic [CH_W-1:0]   r_cfg_chans;
  logic [3:0]        r_credits;
  logic              r_job_done;
  logic              r_err_align;

  logic       w_issue;
  logic       w_ack;
  logic       w_chan_wrap;
  logic       w_last_pair;
  logic       w_job_accept;
  logic       w_in_flight;
  sched_tag_t w_push;
  sched_tag_t w_head;

  assign w_issue      = (r_state == RUN) && i_op_valid && (r_credits != 4'd0);
  // An ack with every slot already free has nothing to return.
  assign w_ack        = i_res_ack && (r_credits != CRED_FULL);
  assign w_chan_wrap  = (r_chan == r_cfg_chans - CH_ONE);
  assign w_last_pair  = w_chan_wrap && (r_tile == r_cfg_tiles - TILE_ONE);
  assign w_job_accept = (r_state == IDLE) && i_job_start;

  always_comb begin
    w_push       = '0;
    w_push.valid = w_issue;
    w_push.tile  = r_tile;
    w_push.chan  = r_chan;
    w_push.last  = w_last_pair;
  end

  winograd_tag_pipe #(
    .DEPTH(MULT_LATENCY)
  ) u_tag_pipe (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_tag      (w_push),
    .o_head     (w_head),
    .o_any_valid(w_in_flight)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_tile      <= '0;
      r_chan      <= '0;
      r_cfg_tiles <= '0;
      r_cfg_chans <= '0;
      r_credits   <= CRED_FULL;
      r_job_done  <= 1'b0;
      r_err_align <= 1'b0;
    end else begin
      r_job_done <= 1'b0;
      if (i_mult_done && !w_head.valid) r_err_align <= 1'b1;

      if (w_issue && !w_ack)      r_credits <= r_credits - 4'd1;
      else if (!w_issue && w_ack) r_credits <= r_credits + 4'd1;

      unique case (r_state)
        IDLE: begin
          if (w_job_accept) begin
            r_tile      <= '0;
            r_chan      <= '0;
            r_cfg_tiles <= i_cfg_tiles;
            r_cfg_chans <= i_cfg_chans;
            if ((i_cfg_tiles != '0) && (i_cfg_chans != '0)) r_state <= RUN;
            else r_job_done <= 1'b1;
          end
        end
        RUN: begin
          if (w_issue) begin
            if (w_last_pair) begin
              r_state <= DRAIN;
              r_tile  <= '0;
              r_chan  <= '0;
            end else if (w_chan_wrap) begin
              r_chan <= '0;
              r_tile <= r_tile + TILE_ONE;
            end else begin
              r_chan <= r_chan + CH_ONE;
            end
          end
        end
        DRAIN: begin
          if (!w_in_flight && (r_credits == CRED_FULL)) begin
            r_state    <= IDLE;
            r_job_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef WINO_SCHED_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stall;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else if (w_job_accept) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else begin
      if ((r_state != IDLE) && (r_perf_cycles != '1)) r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_state == RUN) && i_op_valid && (r_credits == 4'd0) && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign o_perf_cycles = r_perf_cycles;
  assign o_perf_stall  = r_perf_stall;
`endif

  assign o_mult_start = w_issue;
  assign o_op_ready   = w_issue;
  assign o_op_tile    = r_tile;
  assign o_op_chan    = r_chan;
  assign o_res_valid  = i_mult_done && w_head.valid;
  assign o_res_tile   = w_head.tile;
  assign o_res_chan   = w_head.chan;
  assign o_res_last   = w_head.last && o_res_valid;
  assign o_busy       = (r_state != IDLE);
  assign o_job_done   = r_job_done;
  assign o_err_align  = r_err_align;

endmodule

// File: tb/tb_winograd_ewmm_scheduler.sv
// Randomized bench for winograd_ewmm_scheduler against a pair-list / credit-count model.
module tb_winograd_ewmm_scheduler;

  localparam int CREDITS = 4;
  localparam int LAT     = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       job_start;
  logic [7:0] cfg_tiles;
  logic [5:0] cfg_chans;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] op_tile;
  logic [5:0] op_chan;
  logic       mult_start;
  logic       mult_done;
  logic       res_valid;
  logic [7:0] res_tile;
  logic [5:0] res_chan;
  logic       res_last;
  logic       res_ack;
  logic       busy;
  logic       job_done;
  logic       err_align;
`ifdef WINO_SCHED_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  winograd_ewmm_scheduler #(
    .MULT_LATENCY(LAT),
    .TILE_W(8),
    .CH_W(6),
    .CREDITS(CREDITS)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_job_start(job_start),
    .i_cfg_tiles(cfg_tiles),
    .i_cfg_chans(cfg_chans),
    .i_op_valid(op_valid),
    .o_op_ready(op_ready),
    .o_op_tile(op_tile),
    .o_op_chan(op_chan),
    .o_mult_start(mult_start),
    .i_mult_done(mult_done),
    .o_res_valid(res_valid),
    .o_res_tile(res_tile),
    .o_res_chan(res_chan),
    .o_res_last(res_last),
    .i_res_ack(res_ack),
    .o_busy(busy),
    .o_job_done(job_done),
    .o_err_align(err_align)
`ifdef WINO_SCHED_PERF_EN
    ,
    .o_perf_cycles(perf_cycles),
    .o_perf_stall(perf_stall)
`endif
  );

  typedef struct {
    int t;
    int c;
    bit l;
  } exp_tag_t;

  int       n_tests = 0;
  int       n_fail  = 0;
  int       cyc     = 0;
  int       rel     = 0;
  bit       ring [8];
  exp_tag_t res_q [$];

  int m_tiles, m_chans, m_total, m_k, m_out;
  bit m_issuing;
  int pend_ack, job_done_cnt, stall_cnt, act_issue_cnt;
  int op_mode, ack_mode, ack_hold;
  bit inj_start;

  task automatic chk(string tag, int obs, int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs just after the edge, check at the falling edge,
  // then advance the model to what the next edge commits.
  task automatic step();
    bit       ov, ra, md, exp_start;
    exp_tag_t e;
    @(posedge clk); #1;
    cyc++;
    rel++;
    case (op_mode)
      0:       ov = 1'b1;
      1:       ov = (rel % 2 == 1);
      default: ov = ($urandom_range(0, 1) == 1);
    endcase
    md = ring[cyc % 8];
    ring[cyc % 8] = 1'b0;
    case (ack_mode)
      0:       ra = md;
      1:       ra = (pend_ack > 0) && (rel >= ack_hold);
      default: ra = (pend_ack > 0) && ($urandom_range(0, 3) != 0);
    endcase
    op_valid  = ov;
    res_ack   = ra;
    mult_done = md;
    job_start = inj_start && (rel == 5);
    if (job_start) cfg_tiles = 8'd7;
    @(negedge clk);

    exp_start = m_issuing && ov && (m_out < CREDITS);
    chk("mult_start", int'(mult_start), int'(exp_start));
    chk("op_ready", int'(op_ready), int'(exp_start));
    if (mult_start) act_issue_cnt++;
    if (m_issuing) begin
      chk("op_tile", int'(op_tile), m_k / m_chans);
      chk("op_chan", int'(op_chan), m_k % m_chans);
      chk("busy_run", int'(busy), 1);
      if (ov && (m_out == CREDITS)) stall_cnt++;
    end
    chk("res_valid", int'(res_valid), int'(md));
    if (md && (res_q.size() > 0)) begin
      e = res_q.pop_front();
      chk("res_tile", int'(res_tile), e.t);
      chk("res_chan", int'(res_chan), e.c);
      chk("res_last", int'(res_last), int'(e.l));
      if (ack_mode != 0) pend_ack++;
    end
    if (job_done) job_done_cnt++;

    if (exp_start) begin
      e.t = m_k / m_chans;
      e.c = m_k % m_chans;
      e.l = (m_k == m_total - 1);
      res_q.push_back(e);
      ring[(cyc + LAT) % 8] = 1'b1;
      m_k++;
      m_out++;
      if (m_k == m_total) m_issuing = 1'b0;
    end
    if (ra) begin
      m_out--;
      if (ack_mode != 0) pend_ack--;
    end
  endtask

  task automatic start_job(int tiles, int chans);
    m_tiles       = tiles;
    m_chans       = chans;
    m_total       = tiles * chans;
    m_k           = 0;
    m_issuing     = 1'b0;
    job_done_cnt  = 0;
    stall_cnt     = 0;
    act_issue_cnt = 0;
    rel           = 0;
    @(posedge clk); #1;
    cyc++;
    job_start = 1'b1;
    cfg_tiles = 8'(tiles);
    cfg_chans = 6'(chans);
    op_valid  = 1'b0;
    res_ack   = 1'b0;
    mult_done = ring[cyc % 8];
    ring[cyc % 8] = 1'b0;
    @(negedge clk);
    m_issuing = (m_total != 0);
  endtask

  task automatic run_job(int tiles, int chans, int opm, int ackm, int hold, bit inj);
    op_mode   = opm;
    ack_mode  = ackm;
    ack_hold  = hold;
    inj_start = inj;
    start_job(tiles, chans);
    for (int i = 0; i < 2000 && job_done_cnt == 0; i++) begin
      step();
      if (ackm == 1 && rel == hold - 1) chk("credit_cap", act_issue_cnt, CREDITS);
      if (m_total == 0 && rel == 1) begin
        chk("empty_done", int'(job_done), 1);
        chk("empty_busy", int'(busy), 0);
      end
    end
    repeat (3) step();
    chk("job_done_cnt", job_done_cnt, 1);
    chk("issue_cnt", act_issue_cnt, m_total);
    chk("res_left", res_q.size(), 0);
    chk("busy_end", int'(busy), 0);
    chk("err_align", int'(err_align), 0);
`ifdef WINO_SCHED_PERF_EN
    chk("perf_stall", int'(perf_stall), stall_cnt);
`endif
  endtask

  task automatic reset_cycle(bit ov);
    @(posedge clk); #1;
    cyc++;
    rst_n     = 1'b0;
    op_valid  = ov;
    res_ack   = 1'b0;
    job_start = 1'b0;
    mult_done = ring[cyc % 8];
    ring[cyc % 8] = 1'b0;
    @(posedge clk); #1;
    cyc++;
    rst_n     = 1'b1;
    mult_done = ring[cyc % 8];
    ring[cyc % 8] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ring[i] = 1'b0;
    rst_n = 1'b0; job_start = 1'b0; cfg_tiles = '0; cfg_chans = '0;
    op_valid = 1'b0; mult_done = 1'b0; res_ack = 1'b0;
    m_out = 0; pend_ack = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mult_start", int'(mult_start), 0);
    chk("rst_job_done", int'(job_done), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_err_align", int'(err_align), 0);
    chk("rst_op_tile", int'(op_tile), 0);
    rst_n = 1'b1;

    run_job(2, 3, 0, 0, 0, 1'b0);
    run_job(0, 5, 0, 0, 0, 1'b0);
    run_job(3, 0, 0, 0, 0, 1'b0);
    run_job(2, 4, 1, 0, 0, 1'b0);
    run_job(2, 4, 1, 0, 0, 1'b1);
    for (int j = 0; j < 5; j++)
      run_job($urandom_range(1, 3), $urandom_range(1, 6), 2, 2, 0, 1'b0);

    // Abort a job with two pairs in flight; the stale done pulses must flag misalignment.
    op_mode = 0; ack_mode = 0; inj_start = 1'b0;
    start_job(2, 4);
    step();
    step();
    reset_cycle(1'b1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_mult_start", int'(mult_start), 0);
    chk("abort_res_valid", int'(res_valid), 0);
    chk("abort_op_chan", int'(op_chan), 0);
    chk("abort_job_done", int'(job_done), 0);
    @(posedge clk); #1;
    cyc++;
    mult_done = ring[cyc % 8];
    ring[cyc % 8] = 1'b0;
    @(negedge clk);
    chk("abort_err_align", int'(err_align), 1);
    for (int i = 0; i < 8; i++) ring[i] = 1'b0;
    res_q.delete();
    m_out = 0; pend_ack = 0; m_issuing = 1'b0;
    reset_cycle(1'b0);
    chk("rst2_err_align", int'(err_align), 0);

    // Credit stall after the abort also confirms credits were restored to full.
    run_job(1, 8, 0, 1, 20, 1'b0);
    run_job(2, 5, 2, 1, 12, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
